// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: sequential AES SubBytes engine, LANES bytes per clock.
// A 128-bit state is accepted on a valid/ready handshake. It is substituted
// in place over 16/LANES beats, starting at byte 0 (data_in[127:120]). The
// result is then held until the downstream stage takes it.
// Build option: define AES_SUBBYTES_FWD_EN to add the forward S-box, so that
// the mode input picks forward (1) or inverse (0) for each transaction.
// Without the macro only the inverse S-box is built and mode is ignored.
module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

`ifdef AES_SUBBYTES_FWD_EN
    // Forward S-box: invert in the field, then apply the affine map
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   beat_q;
    logic [127:0]    work_q;
    logic [127:0]    work_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];

`ifdef AES_SUBBYTES_FWD_EN
    logic            mode_q;
`else
    logic            unused_mode;
    assign unused_mode = mode;
`endif

    // One S-box per lane; lane gi handles byte beat*LANES+gi
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi] = work_q[(15 - (int'(beat_q) * LANES + gi)) * 8 +: 8];
`ifdef AES_SUBBYTES_FWD_EN
        assign lane_out[gi] = mode_q ? sbox_fwd(lane_in[gi]) : sbox_inv(lane_in[gi]);
`else
        assign lane_out[gi] = sbox_inv(lane_in[gi]);
`endif
    end

    // Write the substituted bytes of the current beat back in place
    always_comb begin
        work_d = work_q;
        for (int i = 0; i < LANES; i++) begin
            work_d[(15 - (int'(beat_q) * LANES + i)) * 8 +: 8] = lane_out[i];
        end
    end

    // Control FSM with registered handshake outputs and the working register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_SUBBYTES_FWD_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q     <= data_in;
`ifdef AES_SUBBYTES_FWD_EN
                        mode_q     <= mode;
`endif
                        beat_q     <= '0;
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    if (beat_q == LAST_BEAT) begin
                        beat_q      <= '0;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    beat_q      <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Testbench for aes_sub_bytes_seq: three instances (LANES = 1, 4, 16), a
// table-driven SubBytes model with a cycle-level handshake scoreboard, and
// directed vectors with hand-computed results.
module tb_aes_sub_bytes_seq;

`ifdef AES_SUBBYTES_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         mode_i    [3];
    logic         out_ready [3];
    logic [127:0] data_in   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] data_out  [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;
        aes_sub_bytes_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .mode      (mode_i[gi]),
            .data_in   (data_in[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .data_out  (data_out[gi]),
            .busy      (busy[gi])
        );
    end

    function automatic int nb(input int u);
        return (u == 0) ? 16 : (u == 1) ? 4 : 1;
    endfunction

    // Standard AES forward S-box; the inverse table is derived from it
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [127:0] sb_model(input logic [127:0] d, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = (m && FWD) ? fwd_t[b] : inv_t[b];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    // Scoreboard: per instance, one pending transaction with its accept edge
    int           ecount = 0;
    bit           pend [3] = '{1'b0, 1'b0, 1'b0};
    int           acc  [3] = '{0, 0, 0};
    logic [127:0] expd [3];

    always @(posedge clk) begin
        ecount <= ecount + 1;
        for (int u = 0; u < 3; u++) begin
            if (rst) begin
                pend[u] <= 1'b0;
            end else if (!pend[u]) begin
                if (in_valid[u]) begin
                    pend[u] <= 1'b1;
                    acc[u]  <= ecount + 1;
                    expd[u] <= sb_model(data_in[u], mode_i[u]);
                end
            end else if (ecount >= acc[u] + nb(u) && out_ready[u]) begin
                pend[u] <= 1'b0;
            end
        end
    end

    // Compare every instance against the scoreboard on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 3; u++) begin
                logic ov;
                ov = pend[u] && (ecount >= acc[u] + nb(u));
                chk($sformatf("u%0d_in_ready", u), 128'(in_ready[u]), 128'(!pend[u]));
                chk($sformatf("u%0d_out_valid", u), 128'(out_valid[u]), 128'(ov));
                chk($sformatf("u%0d_busy", u), 128'(busy[u]), 128'(pend[u] && !ov));
                if (ov) chk($sformatf("u%0d_data_out", u), data_out[u], expd[u]);
            end
        end
    end

    // One transaction on instance u; hold>0 applies that many cycles of backpressure
    task automatic run_txn(input int u, input logic [127:0] d, input logic m,
                           input int hold, input logic [127:0] exp);
        int lat;
        @(posedge clk); #1;
        in_valid[u]  = 1'b1;
        data_in[u]   = d;
        mode_i[u]    = m;
        out_ready[u] = (hold == 0);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        data_in[u]  = ~d;
        mode_i[u]   = ~m;
        lat = 0;
        while (!out_valid[u] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("u%0d_latency", u), 128'(lat), 128'(nb(u)));
        chk($sformatf("u%0d_result", u), data_out[u], exp);
        $display("txn u%0d lanes=%0d mode=%0d in=%h out=%h lat=%0d hold=%0d",
                 u, 16 / nb(u), m, d, data_out[u], lat, hold);
        if (hold > 0) begin
            in_valid[u] = 1'b1;
            data_in[u]  = d ^ 128'h1;
            for (int h = 0; h < hold; h++) begin
                chk($sformatf("u%0d_hold_data", u), data_out[u], exp);
                chk($sformatf("u%0d_hold_in_ready", u), 128'(in_ready[u]), 128'(0));
                @(posedge clk); #1;
            end
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b1;
        end
        @(posedge clk); #1;
        chk($sformatf("u%0d_idle_in_ready", u), 128'(in_ready[u]), 128'(1));
        chk($sformatf("u%0d_idle_out_valid", u), 128'(out_valid[u]), 128'(0));
        out_ready[u] = 1'b0;
    endtask

    localparam logic [127:0] ALL63      = {16{8'h63}};
    localparam logic [127:0] FWD_IN     = 128'h00531000_00000000_00000000_00000000;
    localparam logic [127:0] FWD_EXP    = FWD ? 128'h63edca63_63636363_63636363_63636363
                                              : 128'h52507c52_52525252_52525252_52525252;
    localparam logic [127:0] INVMIX_IN  = 128'h00edca63_63636363_63636363_63636363;
    localparam logic [127:0] INVMIX_EXP = 128'h52531000_00000000_00000000_00000000;
    localparam logic [127:0] M1_63_EXP  = FWD ? {16{8'hfb}} : 128'h0;

    initial begin
        fwd_t = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            mode_i[u]    = 1'b0;
            out_ready[u] = 1'b0;
            data_in[u]   = '0;
        end

        // Pin the model to hand-computed values
        chk("model_inv63", sb_model(ALL63, 1'b0), 128'h0);
        chk("model_fwdmix", sb_model(FWD_IN, 1'b1), FWD_EXP);
        chk("model_invmix", sb_model(INVMIX_IN, 1'b0), INVMIX_EXP);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_rst_in_ready", u), 128'(in_ready[u]), 128'(1));
            chk($sformatf("u%0d_rst_out_valid", u), 128'(out_valid[u]), 128'(0));
            chk($sformatf("u%0d_rst_busy", u), 128'(busy[u]), 128'(0));
            chk($sformatf("u%0d_rst_data_out", u), data_out[u], 128'h0);
        end
        chk_en = 1'b1;

        for (int u = 0; u < 3; u++) begin
            run_txn(u, ALL63, 1'b0, 0, 128'h0);
            run_txn(u, FWD_IN, 1'b1, 0, FWD_EXP);
            run_txn(u, INVMIX_IN, 1'b0, 5, INVMIX_EXP);
            run_txn(u, ALL63, 1'b1, 0, M1_63_EXP);
        end

        // Reset during beat 7 of a LANES=1 transaction
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        data_in[0]  = INVMIX_IN;
        mode_i[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("u0_midbusy_busy", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("u0_abort_in_ready", 128'(in_ready[0]), 128'(1));
        chk("u0_abort_out_valid", 128'(out_valid[0]), 128'(0));
        chk("u0_abort_data_out", data_out[0], 128'h0);
        $display("txn u0 lanes=1 reset at beat 7, transaction abandoned");
        run_txn(0, INVMIX_IN, 1'b0, 0, INVMIX_EXP);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

Parametrised, sequential AES SubBytes engine for the AES-128 datapath. Accepts a 128-bit state through a valid/ready handshake and substitutes `LANES` bytes per clock. It produces the full 128-bit result after `16/LANES` cycles. Per transaction, `mode` selects the forward or inverse S-box, so the encryption and decryption round pipelines share one block.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- `clk` input, 1 bit: clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: `data_in` and `mode` are valid.
- `in_ready` output, 1 bit: the block can accept a state.
- `mode` input, 1 bit: 0 selects the inverse S-box (decrypt), 1 selects the forward S-box (encrypt).
- `data_in` input, 128 bits: input state. Byte 0 is `data_in[127:120]` and byte 15 is `data_in[7:0]`.
- `out_valid` output, 1 bit: `data_out` holds a completed result.
- `out_ready` input, 1 bit: the downstream stage accepts the result.
- `data_out` output, 128 bits: substituted state, using the same byte order as `data_in`.
- `busy` output, 1 bit: high while the block is in state BUSY.

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `data_in` into the working register and latch `mode`.
  - Clear the beat counter and go to BUSY.
- BUSY:
  - Each cycle, beat counter `b` (0 to `16/LANES`-1) selects bytes `b*LANES` through `b*LANES+LANES-1`, starting from byte 0 (MSB end).
  - The selected bytes pass through `LANES` S-box instances in parallel and are written back in place.
  - On the last beat, go to DONE.
  - For `LANES`=16 there is one beat and the counter is constant 0.
- DONE:
  - `out_valid`=1 and `data_out` = working register.
  - On `out_valid & out_ready`, go to IDLE.
- `data_out` is driven from the working register in all states. It is only meaningful while `out_valid`=1.
- `mode` and `data_in` are sampled only at the accept edge. Changes at any other time have no effect.
- `in_ready` is 0 in BUSY and DONE. There is no overlap of transactions.
- `out_ready` is ignored outside DONE.
- Counter width: `$clog2(16/LANES)`, minimum 1 bit.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `data_out`=0, state=IDLE, counter=0.
- `rst` wins over every other event. Asserting it mid-BUSY or in DONE abandons the transaction. The next cycle is IDLE and the result is lost.
- Latency:
  - Accept at edge k.
  - `out_valid` rises after edge k+`16/LANES`: 16 cycles for `LANES`=1, 4 cycles for `LANES`=4, 1 cycle for `LANES`=16.
- If `out_ready` is already 1 when `out_valid` rises, the result transfers at the next edge.
- `in_ready` reasserts the cycle after the output handshake.
- Throughput: one state per `16/LANES`+2 cycles with `out_ready` tied high.
- Backpressure: in DONE, `data_out` and `out_valid` hold stable for as long as `out_ready`=0.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `AES_SUBBYTES_FWD_EN` defined:
  - The forward S-box is instantiated alongside the inverse S-box in every lane.
  - `mode` selects between them per transaction.
- `AES_SUBBYTES_FWD_EN` undefined:
  - Only the inverse S-box is built.
  - `mode` is ignored and every transaction is an inverse SubBytes. This is the decrypt-only build.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Tests are run for `LANES` = 1, 4 and 16.
- Inverse, all 0x63: `mode`=0, `data_in`=128'h6363…63 → `data_out`=128'h0000…00. `out_valid` rises exactly `16/LANES` cycles after accept.
- Forward, mixed bytes (FWD_EN build): `mode`=1, `data_in`=128'h00531000…00 → `data_out` bytes 0..2 = 0x63, 0xED, 0xCA; bytes 3..15 = 0x63.
- Inverse, mixed bytes: `mode`=0, bytes 0..2 = 0x00, 0xED, 0xCA, rest 0x63 → `data_out` bytes 0..2 = 0x52, 0x53, 0x10; rest 0x00.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` rises → `data_out` is stable and `in_ready`=0 throughout.
  - Release `out_ready` → IDLE on the next cycle.
  - A second `in_valid` offered during DONE is not accepted.
- Reset mid-BUSY: with `LANES`=1, assert `rst` at beat 7 → next cycle `in_ready`=1, `out_valid`=0, `data_out`=0. A fresh transaction then completes correctly.
- Mode in a decrypt-only build: with `AES_SUBBYTES_FWD_EN` undefined, `mode`=1 and `data_in` all 0x63 → `data_out` all 0x00 (inverse applied).
